// File: rtl/multicycle_mem_responder.sv
// Slow-memory responder for the multicycle core's unified memory port.
// Accepts one request in IDLE, waits WAIT_CYCLES, then commits/returns with a one-cycle Ready.
module multicycle_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [31:0]     r_adr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic            w_accept;
  logic            w_enter_resp;
  logic [31:0]     w_adr;
  logic [31:0]     w_wdata;
  logic            w_we;
  logic            w_legal;
  logic [AW-1:0]   w_idx;
  logic [31:0]     r_mem [DEPTH];

  // Next-state and wait counter
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CW'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use the live inputs
  always_comb begin
    w_enter_resp = (w_next == S_RESP);
    w_adr        = (r_state == S_IDLE) ? Adr       : r_adr;
    w_wdata      = (r_state == S_IDLE) ? WriteData : r_wdata;
    w_we         = (r_state == S_IDLE) ? MemWrite  : r_we;
    w_legal      = (w_adr[1:0] == 2'b00) && (w_adr[31:2] < 30'(DEPTH));
    w_idx        = w_adr[AW+1:2];
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      ReadData <= 32'h0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      Ready   <= w_enter_resp;
      Busy    <= (w_next != S_IDLE);
      if (w_accept) begin
        r_adr   <= Adr;
        r_wdata <= WriteData;
        r_we    <= MemWrite;
        Fault   <= 1'b0;
      end
      // Later assignment wins when accept and response share an edge
      if (w_enter_resp) begin
        if (!w_legal) begin
          ReadData <= 32'h0;
          Fault    <= 1'b1;
        end else if (!w_we) begin
          ReadData <= r_mem[w_idx];
        end
      end
    end
  end

  // Array is never reset; a write in flight is dropped if Reset is high at the commit edge
  always_ff @(posedge clk) begin
    if (!Reset && w_enter_resp && w_legal && w_we) r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Randomized self-checking bench: two instances (2 and 0 wait states) against a word-array model.
module tb_multicycle_mem_responder;

  logic        clk = 1'b0;
  logic        rst0, rst1, req0, req1, we0, we1;
  logic [31:0] adr0, adr1, wd0, wd1, rd0, rd1;
  logic        rdy0, rdy1, bsy0, bsy1, flt0, flt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [2][64];
  bit          m_known [2][64];
  logic [31:0] m_rd [2];
  bit          m_rd_known [2];
  bit          m_flt [2];

  always #5 clk = ~clk;

  multicycle_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .Reset(rst0), .Req(req0), .MemWrite(we0), .Adr(adr0), .WriteData(wd0),
    .ReadData(rd0), .Ready(rdy0), .Busy(bsy0), .Fault(flt0)
  );

  multicycle_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .Reset(rst1), .Req(req1), .MemWrite(we1), .Adr(adr1), .WriteData(wd1),
    .ReadData(rd1), .Ready(rdy1), .Busy(bsy1), .Fault(flt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] get_rd(input int s);
    return (s == 0) ? rd0 : rd1;
  endfunction
  function automatic logic [31:0] get_rdy(input int s);
    return 32'((s == 0) ? rdy0 : rdy1);
  endfunction
  function automatic logic [31:0] get_bsy(input int s);
    return 32'((s == 0) ? bsy0 : bsy1);
  endfunction
  function automatic logic [31:0] get_flt(input int s);
    return 32'((s == 0) ? flt0 : flt1);
  endfunction

  task automatic drive(input int s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      req0 = r; we0 = w; adr0 = a; wd0 = d;
    end else begin
      req1 = r; we1 = w; adr1 = a; wd1 = d;
    end
  endtask

  // Reference: word array, legality by address arithmetic
  task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a >> 2);
    if ((a % 4) != 0 || idx >= 64) begin
      m_rd[s] = 32'h0; m_rd_known[s] = 1'b1; m_flt[s] = 1'b1;
    end else begin
      m_flt[s] = 1'b0;
      if (w) begin
        m_mem[s][idx] = d; m_known[s][idx] = 1'b1;
      end else begin
        m_rd[s] = m_mem[s][idx]; m_rd_known[s] = m_known[s][idx];
      end
    end
  endtask

  task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit seen;
    @(negedge clk);
    drive(s, 1'b1, w, a, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
    model(s, w, a, d);
    if (wait_of(s) > 0) check("fault_clear_on_accept", get_flt(s), 32'h0);
    n = 1;
    seen = 1'b0;
    while (n < 20) begin
      if (get_rdy(s) == 32'h1) begin
        seen = 1'b1;
        break;
      end
      check("busy_in_wait", get_bsy(s), 32'h1);
      @(posedge clk); #1;
      n++;
    end
    check("ready_seen", 32'(seen), 32'h1);
    check("ready_latency", 32'(n), 32'(wait_of(s) + 1));
    check("busy_in_resp", get_bsy(s), 32'h1);
    check("fault_with_ready", get_flt(s), 32'(m_flt[s]));
    if (m_rd_known[s]) check("read_data", get_rd(s), m_rd[s]);
    @(posedge clk); #1;
    check("ready_pulse_end", get_rdy(s), 32'h0);
    check("busy_idle", get_bsy(s), 32'h0);
    check("fault_hold", get_flt(s), 32'(m_flt[s]));
    if (m_rd_known[s]) check("read_data_hold", get_rd(s), m_rd[s]);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_rd[s] = 32'h0; m_rd_known[s] = 1'b1; m_flt[s] = 1'b0;
      for (int i = 0; i < 64; i++) m_known[s][i] = 1'b0;
    end
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_ready", get_rdy(s), 32'h0);
      check("reset_busy", get_bsy(s), 32'h0);
      check("reset_fault", get_flt(s), 32'h0);
      check("reset_rdata", get_rd(s), 32'h0);
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    // Basic write/read on both latencies
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(1, 1'b1, 32'h8, 32'hCAFEF00D);
    txn(1, 1'b0, 32'h8, 32'h0);

    // Back-to-back requests with Req held high
    txn(0, 1'b1, 32'h0, 32'h1);
    txn(0, 1'b1, 32'h4, 32'h2);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) model(0, 1'b0, adr0, 32'h0);
      @(posedge clk); #1;
      check("hold_busy", get_bsy(0), 32'((k % 4) != 3));
      check("hold_ready", get_rdy(0), 32'((k % 4) == 2));
      if (k % 4 == 2) check("hold_rdata", get_rd(0), ((k / 4) % 2 == 1) ? 32'h2 : 32'h1);
      @(negedge clk);
      if ((k + 1) % 4 == 0) adr0 = (((k + 1) / 4) % 2 == 1) ? 32'h4 : 32'h0;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Illegal accesses leave the array untouched
    txn(0, 1'b1, 32'h12, 32'h5555AAAA);
    txn(0, 1'b1, 32'h100, 32'h6666BBBB);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h0, 32'h0);

    // Fault holds through an idle cycle, clears on next accept
    txn(0, 1'b0, 32'h101, 32'h0);
    @(posedge clk); #1;
    check("fault_idle_hold", get_flt(0), 32'h1);
    txn(0, 1'b0, 32'h4, 32'h0);

    // Reset during WAIT aborts an uncommitted write
    txn(0, 1'b1, 32'h20, 32'hA5A50000);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("abort_busy_before", get_bsy(0), 32'h1);
    #2 rst0 = 1'b1;
    #1;
    check("abort_busy_async", get_bsy(0), 32'h0);
    check("abort_rdata", get_rd(0), 32'h0);
    @(negedge clk);
    rst0 = 1'b0;
    m_rd[0] = 32'h0; m_rd_known[0] = 1'b1; m_flt[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("abort_no_ready", get_rdy(0), 32'h0);
    end
    txn(0, 1'b0, 32'h20, 32'h0);

    // Req together with Reset is not accepted
    @(negedge clk);
    rst1 = 1'b1;
    drive(1, 1'b1, 1'b1, 32'h8, 32'h0BADF00D);
    @(posedge clk); #1;
    check("req_during_reset_busy", get_bsy(1), 32'h0);
    check("req_during_reset_ready", get_rdy(1), 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst1 = 1'b0;
    m_rd[1] = 32'h0; m_rd_known[1] = 1'b1; m_flt[1] = 1'b0;
    txn(1, 1'b0, 32'h8, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int s;
      logic [31:0] a;
      s = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 7)) << 2;
      case ($urandom_range(0, 9))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = 32'h100 + (32'($urandom_range(0, 63)) << 2);
        default: ;
      endcase
      txn(s, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("rand_idle_fault", get_flt(s), 32'(m_flt[s]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
